// File: rtl/cp0_exc_if.sv
// cp0_exc_if: bundle of every signal between the MEM stage / hazard unit /
// fetch and the CP0 exception block.
//   master : pipeline side, drives MEM exception flags and mtc0/mfc0 requests
//   slave  : cp0_exc side, returns flush/redirect, mfc0 data and register views
interface cp0_exc_if;
    logic [5:0]  int_i;
    logic [31:0] pcM;
    logic        is_dsM;
    logic        adelM;
    logic        adesM;
    logic [31:0] bad_addrM;
    logic        syscallM;
    logic        breakM;
    logic        riM;
    logic        ovM;
    logic        eretM;
    logic        validM;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic [31:0] exctype_o;
    logic        flush_o;
    logic [31:0] newpc_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        timer_int_o;

    modport master (
        output int_i, pcM, is_dsM, adelM, adesM, bad_addrM,
               syscallM, breakM, riM, ovM, eretM, validM,
               we_i, waddr_i, raddr_i, wdata_i,
        input  rdata_o, exctype_o, flush_o, newpc_o,
               status_o, cause_o, epc_o, timer_int_o
    );

    modport slave (
        input  int_i, pcM, is_dsM, adelM, adesM, bad_addrM,
               syscallM, breakM, riM, ovM, eretM, validM,
               we_i, waddr_i, raddr_i, wdata_i,
        output rdata_o, exctype_o, flush_o, newpc_o,
               status_o, cause_o, epc_o, timer_int_o
    );
endinterface

// File: rtl/cp0_exc.sv
// cp0_exc: MEM-stage exception collector and CP0 register file.
// Prioritises interrupt / address / instruction exceptions and eret, updates
// Status, Cause, EPC and BadVAddr, and drives flush plus redirect PC.
// Serves mtc0 writes and combinational mfc0 reads.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-high
//   bus  cp0_exc_if.slave (MEM flags, mtc0/mfc0, flush/newpc, register views)
//
// Optional feature macro: CP0_TIMER_EN
//   defined   : Count/Compare timer and timer_int_o latch implemented
//   undefined : Count/Compare read 0, writes ignored, timer_int_o = 0
module cp0_exc #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic      clk,
    input  logic      rst,
    cp0_exc_if.slave  bus
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Status bits software may change: IM[15:8], EXL[1], IE[0]
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    localparam logic [7:0] EXC_INT  = 8'h01;
    localparam logic [7:0] EXC_ADEL = 8'h04;
    localparam logic [7:0] EXC_ADES = 8'h05;
    localparam logic [7:0] EXC_SYS  = 8'h08;
    localparam logic [7:0] EXC_BP   = 8'h09;
    localparam logic [7:0] EXC_RI   = 8'h0a;
    localparam logic [7:0] EXC_OV   = 8'h0c;
    localparam logic [7:0] EXC_ERET = 8'h0e;

    logic [31:0] status_r;
    logic [31:0] epc_r;
    logic [31:0] badvaddr_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        cause_bd;
    logic [7:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic        timer_int;
    logic [31:0] cause_w;

    logic        int_pend;
    logic        fetch_adel;
    logic [7:0]  exc_code;
    logic        flush;
    logic        take_exc;
    logic        take_eret;
    logic        wr;
    logic        exl;

    assign exl        = status_r[1];
    assign cause_w    = {cause_bd, 15'b0, cause_ip, 1'b0, cause_exc, 2'b00};
    assign int_pend   = status_r[0] & ~exl & (|(cause_ip & status_r[15:8]));
    assign fetch_adel = |bus.pcM[1:0];

    always_comb begin
        exc_code = 8'h00;
        if (bus.validM) begin
            if (int_pend)          exc_code = EXC_INT;
            else if (fetch_adel)   exc_code = EXC_ADEL;
            else if (bus.riM)      exc_code = EXC_RI;
            else if (bus.syscallM) exc_code = EXC_SYS;
            else if (bus.breakM)   exc_code = EXC_BP;
            else if (bus.ovM)      exc_code = EXC_OV;
            else if (bus.adelM)    exc_code = EXC_ADEL;
            else if (bus.adesM)    exc_code = EXC_ADES;
            else if (bus.eretM)    exc_code = EXC_ERET;
        end
    end

    assign flush     = (exc_code != 8'h00);
    assign take_eret = (exc_code == EXC_ERET);
    assign take_exc  = flush & ~take_eret;
    // A flushing instruction never commits its own mtc0.
    assign wr        = bus.we_i & ~flush;

    // Status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_r <= STATUS_RESET;
        end else if (take_exc) begin
            status_r[1] <= 1'b1;
        end else if (take_eret) begin
            status_r[1] <= 1'b0;
        end else if (wr && bus.waddr_i == REG_STATUS) begin
            status_r <= (status_r & ~STATUS_WMASK) | (bus.wdata_i & STATUS_WMASK);
        end
    end

    // Cause: hardware IP bits track the interrupt lines every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_bd  <= 1'b0;
            cause_ip  <= 8'h00;
            cause_exc <= 5'd0;
        end else begin
            cause_ip[7:2] <= {bus.int_i[5] | timer_int, bus.int_i[4:0]};
            if (take_exc) begin
                cause_exc <= exc_code[4:0];
                if (!exl) cause_bd <= bus.is_dsM;
            end else if (wr && bus.waddr_i == REG_CAUSE) begin
                cause_ip[1:0] <= bus.wdata_i[9:8];
            end
        end
    end

    // EPC: a nested synchronous exception (EXL already set) keeps the original return point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_r <= 32'h0;
        end else if (take_exc) begin
            if (!exl) epc_r <= bus.is_dsM ? (bus.pcM - 32'd4) : bus.pcM;
        end else if (wr && bus.waddr_i == REG_EPC) begin
            epc_r <= bus.wdata_i;
        end
    end

    // BadVAddr: hardware-only, loaded on address errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr_r <= 32'h0;
        end else if (take_exc && (exc_code == EXC_ADEL || exc_code == EXC_ADES)) begin
            badvaddr_r <= fetch_adel ? bus.pcM : bus.bad_addrM;
        end
    end

`ifdef CP0_TIMER_EN
    logic tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick      <= 1'b0;
            count_r   <= 32'h0;
            compare_r <= 32'h0;
            timer_int <= 1'b0;
        end else begin
            tick <= ~tick;
            if (wr && bus.waddr_i == REG_COUNT) count_r <= bus.wdata_i;
            else if (tick)                      count_r <= count_r + 32'd1;

            if (wr && bus.waddr_i == REG_COMPARE) begin
                compare_r <= bus.wdata_i;
                timer_int <= 1'b0;
            end else if (count_r == compare_r && compare_r != 32'h0) begin
                timer_int <= 1'b1;
            end
        end
    end
`else
    assign count_r   = 32'h0;
    assign compare_r = 32'h0;
    assign timer_int = 1'b0;
`endif

    // mfc0 sees the pre-edge register contents.
    always_comb begin
        bus.rdata_o = 32'h0;
        case (bus.raddr_i)
            REG_BADVADDR: bus.rdata_o = badvaddr_r;
            REG_COUNT:    bus.rdata_o = count_r;
            REG_COMPARE:  bus.rdata_o = compare_r;
            REG_STATUS:   bus.rdata_o = status_r;
            REG_CAUSE:    bus.rdata_o = cause_w;
            REG_EPC:      bus.rdata_o = epc_r;
            default:      bus.rdata_o = 32'h0;
        endcase
    end

    assign bus.exctype_o   = {24'h0, exc_code};
    assign bus.flush_o     = flush;
    assign bus.newpc_o     = take_eret ? epc_r : EXC_VECTOR;
    assign bus.status_o    = status_r;
    assign bus.cause_o     = cause_w;
    assign bus.epc_o       = epc_r;
    assign bus.timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_exc.sv
module tb_cp0_exc;

`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_exc_if bus();

    cp0_exc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_status, m_epc, m_bad, m_count, m_compare;
    logic        m_bd, m_tint, m_tick;
    logic [7:0]  m_ip;
    logic [4:0]  m_exc;

    function automatic logic [7:0] exp_code();
        logic pend;
        pend = m_status[0] && !m_status[1] && ((m_ip & m_status[15:8]) != 8'h0);
        if (!bus.validM)              return 8'h00;
        if (pend)                     return 8'h01;
        if (bus.pcM[1:0] != 2'b00)    return 8'h04;
        if (bus.riM)                  return 8'h0a;
        if (bus.syscallM)             return 8'h08;
        if (bus.breakM)               return 8'h09;
        if (bus.ovM)                  return 8'h0c;
        if (bus.adelM)                return 8'h04;
        if (bus.adesM)                return 8'h05;
        if (bus.eretM)                return 8'h0e;
        return 8'h00;
    endfunction

    function automatic logic [31:0] exp_cause();
        return {m_bd, 15'b0, m_ip, 1'b0, m_exc, 2'b00};
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return TIMER ? m_count : 32'h0;
            5'd11:   return TIMER ? m_compare : 32'h0;
            5'd12:   return m_status;
            5'd13:   return exp_cause();
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [7:0] c;
        logic       wr;
        if (rst) begin
            m_status  <= 32'h0040_0000;
            m_epc     <= 32'h0;
            m_bad     <= 32'h0;
            m_count   <= 32'h0;
            m_compare <= 32'h0;
            m_bd      <= 1'b0;
            m_tint    <= 1'b0;
            m_tick    <= 1'b0;
            m_ip      <= 8'h0;
            m_exc     <= 5'd0;
        end else begin
            c  = exp_code();
            wr = bus.we_i && (c == 8'h00);
            m_ip[7:2] <= {bus.int_i[5] | m_tint, bus.int_i[4:0]};
            if (TIMER) begin
                m_tick <= ~m_tick;
                if (wr && bus.waddr_i == 5'd9) m_count <= bus.wdata_i;
                else if (m_tick)               m_count <= m_count + 1;
                if (wr && bus.waddr_i == 5'd11) begin
                    m_compare <= bus.wdata_i;
                    m_tint    <= 1'b0;
                end else if (m_count == m_compare && m_compare != 0) begin
                    m_tint <= 1'b1;
                end
            end
            if (c == 8'h0e) begin
                m_status[1] <= 1'b0;
            end else if (c != 8'h00) begin
                m_status[1] <= 1'b1;
                m_exc       <= c[4:0];
                if (!m_status[1]) begin
                    m_epc <= bus.is_dsM ? bus.pcM - 4 : bus.pcM;
                    m_bd  <= bus.is_dsM;
                end
                if (c == 8'h04 || c == 8'h05)
                    m_bad <= (bus.pcM[1:0] != 0) ? bus.pcM : bus.bad_addrM;
            end else if (wr) begin
                case (bus.waddr_i)
                    5'd12: m_status <= {m_status[31:16], bus.wdata_i[15:8], m_status[7:2], bus.wdata_i[1:0]};
                    5'd13: m_ip[1:0] <= bus.wdata_i[9:8];
                    5'd14: m_epc <= bus.wdata_i;
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin : compare
        logic [7:0] c;
        forever begin
            @(negedge clk);
            c = exp_code();
            check("flush", {31'b0, bus.flush_o}, {31'b0, c != 8'h00});
            check("exctype", bus.exctype_o, {24'h0, c});
            if (c != 8'h00)
                check("newpc", bus.newpc_o, (c == 8'h0e) ? m_epc : 32'hBFC0_0380);
            check("status", bus.status_o, m_status);
            check("cause", bus.cause_o, exp_cause());
            check("epc", bus.epc_o, m_epc);
            check("rdata", bus.rdata_o, exp_read(bus.raddr_i));
            check("timer_int", {31'b0, bus.timer_int_o}, {31'b0, m_tint});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.int_i = 6'h0;    bus.pcM = 32'hBFC0_0000; bus.is_dsM = 1'b0;
        bus.adelM = 1'b0;    bus.adesM = 1'b0;        bus.bad_addrM = 32'h0;
        bus.syscallM = 1'b0; bus.breakM = 1'b0;       bus.riM = 1'b0;
        bus.ovM = 1'b0;      bus.eretM = 1'b0;        bus.validM = 1'b0;
        bus.we_i = 1'b0;     bus.waddr_i = 5'd0;      bus.wdata_i = 32'h0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d;
        step();
        bus.we_i = 1'b0;
    endtask

    initial begin
        idle();
        bus.raddr_i = 5'd12;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_status", bus.status_o, 32'h0040_0000);
        check("rst_cause", bus.cause_o, 32'h0);
        check("rst_flush", {31'b0, bus.flush_o}, 32'h0);
        check("rst_exctype", bus.exctype_o, 32'h0);

        // store address error
        bus.validM = 1; bus.adesM = 1; bus.bad_addrM = 32'h8000_1003; bus.pcM = 32'hBFC0_0100;
        #1;
        check("ades_flush", {31'b0, bus.flush_o}, 32'h1);
        check("ades_newpc", bus.newpc_o, 32'hBFC0_0380);
        check("ades_code", bus.exctype_o, 32'h05);
        step(); idle(); bus.raddr_i = 5'd8; #1;
        check("ades_epc", bus.epc_o, 32'hBFC0_0100);
        check("ades_bad", bus.rdata_o, 32'h8000_1003);
        check("ades_exccode", bus.cause_o & 32'h7c, 32'h14);
        check("ades_exl", bus.status_o & 32'h2, 32'h2);
        mtc0(5'd12, 32'h0);

        // fetch AdEL outranks Ov and data AdEL
        bus.validM = 1; bus.pcM = 32'hBFC0_0202; bus.adelM = 1; bus.ovM = 1; bus.bad_addrM = 32'h1111_0000;
        #1 check("fadel_code", bus.exctype_o, 32'h04);
        step(); idle(); #1;
        check("fadel_bad", bus.rdata_o, 32'hBFC0_0202);
        mtc0(5'd12, 32'h0);

        // bubble carries nothing
        bus.syscallM = 1; #1;
        check("bubble_flush", {31'b0, bus.flush_o}, 32'h0);
        step(); idle();

        // syscall in delay slot
        bus.validM = 1; bus.syscallM = 1; bus.is_dsM = 1; bus.pcM = 32'hBFC0_0304;
        #1 check("sys_code", bus.exctype_o, 32'h08);
        step(); idle(); #1;
        check("sys_epc", bus.epc_o, 32'hBFC0_0300);
        check("sys_bd", bus.cause_o & 32'h8000_0000, 32'h8000_0000);

        // break with EXL already set keeps EPC
        bus.validM = 1; bus.breakM = 1; bus.pcM = 32'hBFC0_0400;
        #1 check("bp_code", bus.exctype_o, 32'h09);
        step(); idle(); #1;
        check("bp_epc_kept", bus.epc_o, 32'hBFC0_0300);

        // eret
        bus.validM = 1; bus.eretM = 1; #1;
        check("eret_newpc", bus.newpc_o, 32'hBFC0_0300);
        check("eret_code", bus.exctype_o, 32'h0e);
        step(); idle(); #1;
        check("eret_exl", bus.status_o & 32'h2, 32'h0);

        // RI beats a same-cycle mtc0 EPC
        bus.validM = 1; bus.riM = 1; bus.pcM = 32'hBFC0_0500;
        bus.we_i = 1; bus.waddr_i = 5'd14; bus.wdata_i = 32'h1234;
        #1 check("ri_code", bus.exctype_o, 32'h0a);
        step(); idle(); #1;
        check("ri_epc", bus.epc_o, 32'hBFC0_0500);
        mtc0(5'd12, 32'h0);

        // mfc0 returns pre-edge value
        bus.raddr_i = 5'd14; bus.we_i = 1; bus.waddr_i = 5'd14; bus.wdata_i = 32'h1234;
        #1 check("mfc0_old", bus.rdata_o, 32'hBFC0_0500);
        step(); bus.we_i = 0; #1;
        check("mfc0_new", bus.rdata_o, 32'h1234);

        // BadVAddr read-only, unmapped register reads 0
        mtc0(5'd8, 32'hDEAD_BEEF);
        bus.raddr_i = 5'd8; #1 check("bad_ro", bus.rdata_o, 32'hBFC0_0202);
        mtc0(5'd5, 32'hFFFF_FFFF);
        bus.raddr_i = 5'd5; #1 check("unmapped", bus.rdata_o, 32'h0);

        // hardware interrupt outranks fetch AdEL
        mtc0(5'd12, 32'h0000_0401);
        bus.int_i = 6'h01; step(); #1;
        check("int_ip2", bus.cause_o & 32'h400, 32'h400);
        bus.validM = 1; bus.pcM = 32'hBFC0_0602; bus.syscallM = 1;
        #1 check("int_code", bus.exctype_o, 32'h01);
        step(); idle(); #1;
        check("int_epc", bus.epc_o, 32'hBFC0_0602);

`ifdef CP0_TIMER_EN
        begin : timer_blk
            bit seen;
            seen = 1'b0;
            mtc0(5'd12, 32'h0);
            mtc0(5'd9, 32'h0);
            mtc0(5'd11, 32'h10);
            mtc0(5'd12, 32'h0000_8001);
            bus.raddr_i = 5'd9;
            for (int i = 0; i < 200 && !seen; i++) begin
                step();
                if (bus.timer_int_o) seen = 1'b1;
            end
            check("timer_seen", {31'b0, seen}, 32'h1);
            check("timer_count", {31'b0, (bus.rdata_o == 32'h10 || bus.rdata_o == 32'h11)}, 32'h1);
            step();
            bus.validM = 1; #1;
            check("timer_code", bus.exctype_o, 32'h01);
            step(); idle();
            mtc0(5'd11, 32'h1000); #1;
            check("timer_clear", {31'b0, bus.timer_int_o}, 32'h0);
            mtc0(5'd9, 32'h55);
        end
`else
        mtc0(5'd9, 32'h55);
        mtc0(5'd11, 32'h10);
        bus.raddr_i = 5'd9; #1;
        check("count_off", bus.rdata_o, 32'h0);
        check("timer_off", {31'b0, bus.timer_int_o}, 32'h0);
`endif

        // asynchronous reset with EXL set
        bus.validM = 1; bus.syscallM = 1; step(); idle();
        bus.raddr_i = 5'd9;
        #2 rst = 1'b1;
        #1;
        check("arst_status", bus.status_o, 32'h0040_0000);
        check("arst_count", bus.rdata_o, 32'h0);
        check("arst_flush", {31'b0, bus.flush_o}, 32'h0);
        step(); rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
